// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: captures a binary value, converts it to BCD with
// sequential shift-add-3, and scans DIGITS common lines over one shared segment bus.
module seg7_scan_driver #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DIGITS          = 4,
   parameter int unsigned DIV             = 1000,
   parameter bit          BLANK_LZ        = 1'b1,
   parameter bit          COM_ACTIVE_HIGH = 1'b1,
   parameter bit          SEG_ACTIVE_HIGH = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WIDTH-1:0]  A,
   input  logic              load,
   output logic              busy,
   output logic              overflow,
   output logic [DIGITS-1:0] com,
   output logic [6:0]        data_out
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Largest displayable value, saturated at 2^WIDTH (meaning "never overflows").
   function automatic logic [WIDTH:0] max_disp();
      logic [WIDTH+4:0] v;
      logic [WIDTH+4:0] sat;
      v   = '0;
      sat = {4'b0000, 1'b1, {WIDTH{1'b0}}};
      for (int i = 0; i < int'(DIGITS); i++) begin
         v = v * (WIDTH+5)'(10) + (WIDTH+5)'(9);
         if (v > sat) v = sat;
      end
      return v[WIDTH:0];
   endfunction

   localparam logic [WIDTH:0] MaxDisp = max_disp();

   typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic [BW-1:0]     dig_q, dig_d;
   logic              overflow_q, overflow_d;
   logic [PW-1:0]     presc_q;
   logic [SW-1:0]     scan_q;
   logic [DIGITS-1:0] com_q, com_raw;
   logic [6:0]        seg_q, seg_raw;
   logic [DIGITS-1:0] lz;
   logic [3:0]        nib;

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      dig_d      = dig_q;
      overflow_d = overflow_q;
      bcd_adj    = bcd_q;
      case (state_q)
         StIdle: begin
            if (load) begin
               bin_d      = A;
               bcd_d      = '0;
               cnt_d      = CW'(WIDTH);
               ovf_pend_d = ({1'b0, A} > MaxDisp);
               state_d    = StShift;
            end
         end
         StShift: begin
            for (int i = 0; i < int'(DIGITS); i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            // The top bit of the accumulator is discarded on each shift.
            {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = StCommit;
         end
         StCommit: begin
            dig_d      = bcd_q;
            overflow_d = ovf_pend_q;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         dig_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         dig_q      <= dig_d;
         overflow_q <= overflow_d;
      end
   end

   // lz[i]: digits i..DIGITS-1 are all zero.
   always_comb begin
      lz = '0;
      lz[DIGITS-1] = (dig_q[BW-1 -: 4] == 4'd0);
      for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
         lz[i] = (dig_q[4*i +: 4] == 4'd0) && lz[i+1];
      end
   end

   always_comb begin
      nib        = dig_q[4*scan_q +: 4];
      com_raw    = '0;
      com_raw[scan_q] = 1'b1;
      seg_raw    = 7'h00;
      if (overflow_q) begin
         seg_raw = 7'h40;
      end else if (BLANK_LZ && (scan_q != '0) && lz[scan_q]) begin
         seg_raw = 7'h00;
      end else begin
         case (nib)
            4'd0:    seg_raw = 7'h3F;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5B;
            4'd3:    seg_raw = 7'h4F;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6D;
            4'd6:    seg_raw = 7'h7D;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h6F;
            default: seg_raw = 7'h00;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         scan_q  <= '0;
         com_q   <= COM_ACTIVE_HIGH ? '0 : '1;
         seg_q   <= SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;
      end else begin
         if (presc_q == PW'(DIV - 1)) begin
            presc_q <= '0;
            scan_q  <= (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
         end else begin
            presc_q <= presc_q + 1'b1;
         end
         com_q <= COM_ACTIVE_HIGH ? com_raw : ~com_raw;
         seg_q <= SEG_ACTIVE_HIGH ? seg_raw : ~seg_raw;
      end
   end

   assign busy     = (state_q != StIdle);
   assign overflow = overflow_q;
   assign com      = com_q;
   assign data_out = seg_q;

endmodule
